// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: IF/ID, ID/EX and EX/MEM pipeline registers with sync reset.
// Define PIPE_FLUSH_EN to add a flush input that bubbles the IF/ID and ID/EX banks.
module pipeline_stage_regs (
    input  logic        clk,
    input  logic        rst,
`ifdef PIPE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [63:0] if_id_pc_in,
    input  logic [31:0] if_id_instruction_in,
    output logic [63:0] if_id_pc_out,
    output logic [31:0] if_id_instruction_out,
    input  logic [63:0] id_ex_pc_in,
    input  logic [63:0] id_ex_read_data1_in,
    input  logic [63:0] id_ex_read_data2_in,
    input  logic [63:0] id_ex_imm_val_in,
    input  logic [4:0]  id_ex_write_reg_in,
    input  logic [9:0]  id_ex_alu_control_in,
    input  logic        id_ex_alusrc_in,
    input  logic        id_ex_branch_in,
    input  logic        id_ex_memwrite_in,
    input  logic        id_ex_memread_in,
    input  logic        id_ex_memtoreg_in,
    input  logic        id_ex_regwrite_in,
    output logic [63:0] id_ex_pc_out,
    output logic [63:0] id_ex_read_data1_out,
    output logic [63:0] id_ex_read_data2_out,
    output logic [63:0] id_ex_imm_val_out,
    output logic [4:0]  id_ex_write_reg_out,
    output logic [9:0]  id_ex_alu_control_out,
    output logic        id_ex_alusrc_out,
    output logic        id_ex_branch_out,
    output logic        id_ex_memwrite_out,
    output logic        id_ex_memread_out,
    output logic        id_ex_memtoreg_out,
    output logic        id_ex_regwrite_out,
    input  logic [63:0] ex_mem_pc_in,
    input  logic        ex_mem_zero_in,
    input  logic [31:0] ex_mem_alu_result_in,
    input  logic [31:0] ex_mem_read_data2_in,
    input  logic [4:0]  ex_mem_write_reg_in,
    input  logic        ex_mem_branch_in,
    input  logic        ex_mem_memwrite_in,
    input  logic        ex_mem_memread_in,
    input  logic        ex_mem_memtoreg_in,
    input  logic        ex_mem_regwrite_in,
    output logic [63:0] ex_mem_pc_out,
    output logic        ex_mem_zero_out,
    output logic [31:0] ex_mem_alu_result_out,
    output logic [31:0] ex_mem_read_data2_out,
    output logic [4:0]  ex_mem_write_reg_out,
    output logic        ex_mem_branch_out,
    output logic        ex_mem_memwrite_out,
    output logic        ex_mem_memread_out,
    output logic        ex_mem_memtoreg_out,
    output logic        ex_mem_regwrite_out
);
    logic clr_front;
`ifdef PIPE_FLUSH_EN
    assign clr_front = rst | flush;
`else
    assign clr_front = rst;
`endif
    // EX/MEM holds the branch itself, so only the two younger banks see flush
    always_ff @(posedge clk) begin
        if (clr_front) begin
            if_id_pc_out          <= '0;
            if_id_instruction_out <= '0;
            id_ex_pc_out          <= '0;
            id_ex_read_data1_out  <= '0;
            id_ex_read_data2_out  <= '0;
            id_ex_imm_val_out     <= '0;
            id_ex_write_reg_out   <= '0;
            id_ex_alu_control_out <= '0;
            id_ex_alusrc_out      <= 1'b0;
            id_ex_branch_out      <= 1'b0;
            id_ex_memwrite_out    <= 1'b0;
            id_ex_memread_out     <= 1'b0;
            id_ex_memtoreg_out    <= 1'b0;
            id_ex_regwrite_out    <= 1'b0;
        end else begin
            if_id_pc_out          <= if_id_pc_in;
            if_id_instruction_out <= if_id_instruction_in;
            id_ex_pc_out          <= id_ex_pc_in;
            id_ex_read_data1_out  <= id_ex_read_data1_in;
            id_ex_read_data2_out  <= id_ex_read_data2_in;
            id_ex_imm_val_out     <= id_ex_imm_val_in;
            id_ex_write_reg_out   <= id_ex_write_reg_in;
            id_ex_alu_control_out <= id_ex_alu_control_in;
            id_ex_alusrc_out      <= id_ex_alusrc_in;
            id_ex_branch_out      <= id_ex_branch_in;
            id_ex_memwrite_out    <= id_ex_memwrite_in;
            id_ex_memread_out     <= id_ex_memread_in;
            id_ex_memtoreg_out    <= id_ex_memtoreg_in;
            id_ex_regwrite_out    <= id_ex_regwrite_in;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_pc_out         <= '0;
            ex_mem_zero_out       <= 1'b0;
            ex_mem_alu_result_out <= '0;
            ex_mem_read_data2_out <= '0;
            ex_mem_write_reg_out  <= '0;
            ex_mem_branch_out     <= 1'b0;
            ex_mem_memwrite_out   <= 1'b0;
            ex_mem_memread_out    <= 1'b0;
            ex_mem_memtoreg_out   <= 1'b0;
            ex_mem_regwrite_out   <= 1'b0;
        end else begin
            ex_mem_pc_out         <= ex_mem_pc_in;
            ex_mem_zero_out       <= ex_mem_zero_in;
            ex_mem_alu_result_out <= ex_mem_alu_result_in;
            ex_mem_read_data2_out <= ex_mem_read_data2_in;
            ex_mem_write_reg_out  <= ex_mem_write_reg_in;
            ex_mem_branch_out     <= ex_mem_branch_in;
            ex_mem_memwrite_out   <= ex_mem_memwrite_in;
            ex_mem_memread_out    <= ex_mem_memread_in;
            ex_mem_memtoreg_out   <= ex_mem_memtoreg_in;
            ex_mem_regwrite_out   <= ex_mem_regwrite_in;
        end
    end
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs: randomized check of the three pipeline banks against a one-edge delay model.
module tb_pipeline_stage_regs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [95:0]  ifid_in = '0;
    logic [276:0] idex_in = '0;
    logic [138:0] exmem_in = '0;
    logic [95:0]  ifid_out;
    logic [276:0] idex_out;
    logic [138:0] exmem_out;
    logic [63:0] if_id_pc_in, if_id_pc_out, id_ex_pc_in, id_ex_pc_out;
    logic [31:0] if_id_instruction_in, if_id_instruction_out;
    logic [63:0] id_ex_read_data1_in, id_ex_read_data1_out, id_ex_read_data2_in, id_ex_read_data2_out;
    logic [63:0] id_ex_imm_val_in, id_ex_imm_val_out;
    logic [4:0]  id_ex_write_reg_in, id_ex_write_reg_out;
    logic [9:0]  id_ex_alu_control_in, id_ex_alu_control_out;
    logic id_ex_alusrc_in, id_ex_branch_in, id_ex_memwrite_in, id_ex_memread_in, id_ex_memtoreg_in, id_ex_regwrite_in;
    logic id_ex_alusrc_out, id_ex_branch_out, id_ex_memwrite_out, id_ex_memread_out, id_ex_memtoreg_out, id_ex_regwrite_out;
    logic [63:0] ex_mem_pc_in, ex_mem_pc_out;
    logic ex_mem_zero_in, ex_mem_zero_out;
    logic [31:0] ex_mem_alu_result_in, ex_mem_alu_result_out, ex_mem_read_data2_in, ex_mem_read_data2_out;
    logic [4:0]  ex_mem_write_reg_in, ex_mem_write_reg_out;
    logic ex_mem_branch_in, ex_mem_memwrite_in, ex_mem_memread_in, ex_mem_memtoreg_in, ex_mem_regwrite_in;
    logic ex_mem_branch_out, ex_mem_memwrite_out, ex_mem_memread_out, ex_mem_memtoreg_out, ex_mem_regwrite_out;

    assign {if_id_pc_in, if_id_instruction_in} = ifid_in;
    assign {id_ex_pc_in, id_ex_read_data1_in, id_ex_read_data2_in, id_ex_imm_val_in, id_ex_write_reg_in,
            id_ex_alu_control_in, id_ex_alusrc_in, id_ex_branch_in, id_ex_memwrite_in, id_ex_memread_in,
            id_ex_memtoreg_in, id_ex_regwrite_in} = idex_in;
    assign {ex_mem_pc_in, ex_mem_zero_in, ex_mem_alu_result_in, ex_mem_read_data2_in, ex_mem_write_reg_in,
            ex_mem_branch_in, ex_mem_memwrite_in, ex_mem_memread_in, ex_mem_memtoreg_in, ex_mem_regwrite_in} = exmem_in;
    assign ifid_out = {if_id_pc_out, if_id_instruction_out};
    assign idex_out = {id_ex_pc_out, id_ex_read_data1_out, id_ex_read_data2_out, id_ex_imm_val_out, id_ex_write_reg_out,
                       id_ex_alu_control_out, id_ex_alusrc_out, id_ex_branch_out, id_ex_memwrite_out, id_ex_memread_out,
                       id_ex_memtoreg_out, id_ex_regwrite_out};
    assign exmem_out = {ex_mem_pc_out, ex_mem_zero_out, ex_mem_alu_result_out, ex_mem_read_data2_out, ex_mem_write_reg_out,
                        ex_mem_branch_out, ex_mem_memwrite_out, ex_mem_memread_out, ex_mem_memtoreg_out, ex_mem_regwrite_out};

    pipeline_stage_regs dut (
        .clk(clk), .rst(rst),
`ifdef PIPE_FLUSH_EN
        .flush(flush),
`endif
        .if_id_pc_in(if_id_pc_in), .if_id_instruction_in(if_id_instruction_in),
        .if_id_pc_out(if_id_pc_out), .if_id_instruction_out(if_id_instruction_out),
        .id_ex_pc_in(id_ex_pc_in), .id_ex_read_data1_in(id_ex_read_data1_in), .id_ex_read_data2_in(id_ex_read_data2_in),
        .id_ex_imm_val_in(id_ex_imm_val_in), .id_ex_write_reg_in(id_ex_write_reg_in), .id_ex_alu_control_in(id_ex_alu_control_in),
        .id_ex_alusrc_in(id_ex_alusrc_in), .id_ex_branch_in(id_ex_branch_in), .id_ex_memwrite_in(id_ex_memwrite_in),
        .id_ex_memread_in(id_ex_memread_in), .id_ex_memtoreg_in(id_ex_memtoreg_in), .id_ex_regwrite_in(id_ex_regwrite_in),
        .id_ex_pc_out(id_ex_pc_out), .id_ex_read_data1_out(id_ex_read_data1_out), .id_ex_read_data2_out(id_ex_read_data2_out),
        .id_ex_imm_val_out(id_ex_imm_val_out), .id_ex_write_reg_out(id_ex_write_reg_out), .id_ex_alu_control_out(id_ex_alu_control_out),
        .id_ex_alusrc_out(id_ex_alusrc_out), .id_ex_branch_out(id_ex_branch_out), .id_ex_memwrite_out(id_ex_memwrite_out),
        .id_ex_memread_out(id_ex_memread_out), .id_ex_memtoreg_out(id_ex_memtoreg_out), .id_ex_regwrite_out(id_ex_regwrite_out),
        .ex_mem_pc_in(ex_mem_pc_in), .ex_mem_zero_in(ex_mem_zero_in), .ex_mem_alu_result_in(ex_mem_alu_result_in),
        .ex_mem_read_data2_in(ex_mem_read_data2_in), .ex_mem_write_reg_in(ex_mem_write_reg_in), .ex_mem_branch_in(ex_mem_branch_in),
        .ex_mem_memwrite_in(ex_mem_memwrite_in), .ex_mem_memread_in(ex_mem_memread_in), .ex_mem_memtoreg_in(ex_mem_memtoreg_in),
        .ex_mem_regwrite_in(ex_mem_regwrite_in),
        .ex_mem_pc_out(ex_mem_pc_out), .ex_mem_zero_out(ex_mem_zero_out), .ex_mem_alu_result_out(ex_mem_alu_result_out),
        .ex_mem_read_data2_out(ex_mem_read_data2_out), .ex_mem_write_reg_out(ex_mem_write_reg_out), .ex_mem_branch_out(ex_mem_branch_out),
        .ex_mem_memwrite_out(ex_mem_memwrite_out), .ex_mem_memread_out(ex_mem_memread_out), .ex_mem_memtoreg_out(ex_mem_memtoreg_out),
        .ex_mem_regwrite_out(ex_mem_regwrite_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_all();
        for (int i = 0; i < 96; i++) ifid_in[i] = 1'($urandom);
        for (int i = 0; i < 277; i++) idex_in[i] = 1'($urandom);
        for (int i = 0; i < 139; i++) exmem_in[i] = 1'($urandom);
    endtask

    task automatic test_reset();
        ifid_in = {64'h1234, 32'h00B50533};
        idex_in = '1;
        exmem_in = '1;
        rst = 1'b1;
        tick();
        tests++; if (ifid_out !== '0) begin fails++; $display("FAIL reset_ifid got %h want 0", ifid_out); end
        tests++; if (idex_out !== '0) begin fails++; $display("FAIL reset_idex got %h want 0", idex_out); end
        tests++; if (exmem_out !== '0) begin fails++; $display("FAIL reset_exmem got %h want 0", exmem_out); end
        rst = 1'b0;
        #3;
        tests++; if (idex_out !== '0) begin fails++; $display("FAIL hold_between_edges got %h want 0", idex_out); end
    endtask

    task automatic test_pass_through();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifid_in = {64'h10, 32'h00A58633};
        #2;
        tests++; if (ifid_out !== '0) begin fails++; $display("FAIL pass_before_edge got %h want 0", ifid_out); end
        tick();
        tests++; if (if_id_pc_out !== 64'h10) begin fails++; $display("FAIL pass_pc got %h want 10", if_id_pc_out); end
        tests++; if (if_id_instruction_out !== 32'h00A58633) begin fails++; $display("FAIL pass_instr got %h want 00a58633", if_id_instruction_out); end
    endtask

    task automatic test_id_ex_full_width();
        logic [276:0] exp;
        exp = {64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0A, 64'h8000_0000_0000_0000, 5'd31, 10'h3FF, 6'b111111};
        idex_in = exp;
        tick();
        tests++; if (idex_out !== exp) begin fails++; $display("FAIL idex_full got %h want %h", idex_out, exp); end
        tests++; if (id_ex_regwrite_out !== 1'b1) begin fails++; $display("FAIL idex_regwrite got %b want 1", id_ex_regwrite_out); end
        idex_in = '0;
        tick();
        tests++; if (idex_out !== '0) begin fails++; $display("FAIL idex_zero got %h want 0", idex_out); end
    endtask

    task automatic test_ex_mem();
        logic [138:0] exp;
        exp = {64'h20, 1'b1, 32'hF8, 32'h1F, 5'd5, 1'b0, 1'b1, 3'b000};
        exmem_in = exp;
        tick();
        tests++; if (exmem_out !== exp) begin fails++; $display("FAIL exmem got %h want %h", exmem_out, exp); end
        tests++; if (ex_mem_alu_result_out !== 32'hF8) begin fails++; $display("FAIL exmem_alu got %h want f8", ex_mem_alu_result_out); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 64'(i * 4);
            ifid_in = {exp, $urandom};
            tick();
            tests++; if (if_id_pc_out !== exp) begin fails++; $display("FAIL stream_%0d got %h want %h", i, if_id_pc_out, exp); end
        end
        ifid_in = {64'd16, 32'h13};
        rst = 1'b1;
        tick();
        tests++; if (if_id_pc_out !== '0) begin fails++; $display("FAIL stream_rst got %h want 0", if_id_pc_out); end
        rst = 1'b0;
        ifid_in = {64'd20, 32'h13};
        tick();
        tests++; if (if_id_pc_out !== 64'd20) begin fails++; $display("FAIL stream_resume got %h want 14", if_id_pc_out); end
    endtask

    task automatic test_random();
        logic [95:0] e_ifid;
        logic [276:0] e_idex;
        logic [138:0] e_exmem;
        logic kill_front;
        for (int n = 0; n < 60; n++) begin
            rand_all();
            rst = ($urandom_range(0, 7) == 0);
`ifdef PIPE_FLUSH_EN
            flush = ($urandom_range(0, 5) == 0);
`endif
            kill_front = rst | flush;
            e_ifid = kill_front ? '0 : ifid_in;
            e_idex = kill_front ? '0 : idex_in;
            e_exmem = rst ? '0 : exmem_in;
            tick();
            tests++; if (ifid_out !== e_ifid) begin fails++; $display("FAIL rand_ifid_%0d got %h want %h", n, ifid_out, e_ifid); end
            tests++; if (idex_out !== e_idex) begin fails++; $display("FAIL rand_idex_%0d got %h want %h", n, idex_out, e_idex); end
            tests++; if (exmem_out !== e_exmem) begin fails++; $display("FAIL rand_exmem_%0d got %h want %h", n, exmem_out, e_exmem); end
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

`ifdef PIPE_FLUSH_EN
    task automatic test_flush();
        logic [138:0] e_exmem;
        rand_all();
        idex_in[0] = 1'b1;
        exmem_in[0] = 1'b1;
        e_exmem = exmem_in;
        rst = 1'b0;
        flush = 1'b1;
        tick();
        tests++; if (ifid_out !== '0) begin fails++; $display("FAIL flush_ifid got %h want 0", ifid_out); end
        tests++; if (idex_out !== '0) begin fails++; $display("FAIL flush_idex got %h want 0", idex_out); end
        tests++; if (exmem_out !== e_exmem) begin fails++; $display("FAIL flush_exmem got %h want %h", exmem_out, e_exmem); end
        tests++; if (ex_mem_regwrite_out !== 1'b1) begin fails++; $display("FAIL flush_regwrite got %b want 1", ex_mem_regwrite_out); end
        rst = 1'b1;
        tick();
        tests++; if ({ifid_out, idex_out, exmem_out} !== '0) begin fails++; $display("FAIL flush_rst got %h want 0", {ifid_out, idex_out, exmem_out}); end
        rst = 1'b0;
        flush = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_id_ex_full_width();
        test_ex_mem();
        test_back_to_back();
`ifdef PIPE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
